// File: rtl/anton_neopixel_bus_arbiter.sv
// Round-robin two-master arbiter for the NeoPixel controller byte bus. It can
// hold pixel-buffer writes until the strip's reset/latch window is open.
module anton_neopixel_bus_arbiter #(
    parameter int unsigned ADDR_BITS = 14
) (
    input  logic                 busClk,
    input  logic                 busReset,
    input  logic                 m0Req,
    input  logic                 m0Write,
    input  logic [ADDR_BITS-1:0] m0Addr,
    input  logic [7:0]           m0DataIn,
    output logic                 m0Ack,
    output logic [7:0]           m0DataOut,
    input  logic                 m1Req,
    input  logic                 m1Write,
    input  logic [ADDR_BITS-1:0] m1Addr,
    input  logic [7:0]           m1DataIn,
    output logic                 m1Ack,
    output logic [7:0]           m1DataOut,
    input  logic                 syncLockEn,
    input  logic                 pixelsSync,
    output logic [ADDR_BITS-1:0] busAddr,
    output logic [7:0]           busDataIn,
    output logic                 busWrite,
    output logic                 busRead,
    input  logic [7:0]           busDataOut,
    output logic [1:0]           grant
);
    localparam int unsigned MSB = ADDR_BITS - 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   ptr;
    logic                   ptr_nxt;
    logic                   elig0;
    logic                   elig1;
    logic                   pick1;
    logic                   any_elig;
    logic [1:0]             grant_nxt;
    logic [ADDR_BITS-1:0]   addr_nxt;
    logic [7:0]             data_nxt;
    logic                   write_nxt;
    logic                   read_nxt;
    logic                   ack0_nxt;
    logic                   ack1_nxt;
    logic [7:0]             dout0_nxt;
    logic [7:0]             dout1_nxt;

    // A buffer write is held back while locking is on and the latch window is closed
    assign elig0    = m0Req & ~(m0Write & ~m0Addr[MSB] & syncLockEn & ~pixelsSync);
    assign elig1    = m1Req & ~(m1Write & ~m1Addr[MSB] & syncLockEn & ~pixelsSync);
    assign any_elig = elig0 | elig1;
    assign pick1    = elig1 & (~elig0 | ptr);

    always_ff @(posedge busClk) begin
        if (busReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_elig) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = busWrite ? S_ACK : S_WAIT;
            S_WAIT:  state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the bus address/data registers double as the transaction latch
    always_comb begin
        grant_nxt = grant;
        addr_nxt  = busAddr;
        data_nxt  = busDataIn;
        write_nxt = 1'b0;
        read_nxt  = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        dout0_nxt = m0DataOut;
        dout1_nxt = m1DataOut;
        ptr_nxt   = ptr;
        case (state)
            S_IDLE: begin
                if (any_elig) begin
                    grant_nxt = pick1 ? 2'b10 : 2'b01;
                    addr_nxt  = pick1 ? m1Addr : m0Addr;
                    data_nxt  = pick1 ? m1DataIn : m0DataIn;
                    write_nxt = pick1 ? m1Write : m0Write;
                    read_nxt  = pick1 ? ~m1Write : ~m0Write;
                end
            end
            S_ISSUE: begin
                ack0_nxt = busWrite & grant[0];
                ack1_nxt = busWrite & grant[1];
            end
            S_WAIT: begin
                ack0_nxt = grant[0];
                ack1_nxt = grant[1];
                if (grant[1]) begin
                    dout1_nxt = busDataOut;
                end else begin
                    dout0_nxt = busDataOut;
                end
            end
            S_ACK: begin
                grant_nxt = 2'b00;
                ptr_nxt   = ~grant[1];
            end
            default: grant_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge busClk) begin
        if (busReset) begin
            grant     <= 2'b00;
            busAddr   <= '0;
            busDataIn <= 8'h00;
            busWrite  <= 1'b0;
            busRead   <= 1'b0;
            m0Ack     <= 1'b0;
            m1Ack     <= 1'b0;
            m0DataOut <= 8'h00;
            m1DataOut <= 8'h00;
            ptr       <= 1'b0;
        end else begin
            grant     <= grant_nxt;
            busAddr   <= addr_nxt;
            busDataIn <= data_nxt;
            busWrite  <= write_nxt;
            busRead   <= read_nxt;
            m0Ack     <= ack0_nxt;
            m1Ack     <= ack1_nxt;
            m0DataOut <= dout0_nxt;
            m1DataOut <= dout1_nxt;
            ptr       <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// Bench for the NeoPixel bus arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-schedule reference model.
module tb_anton_neopixel_bus_arbiter;
    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    wr;
    logic [AW-1:0] addr [2];
    logic [7:0]    wdat [2];
    logic          lock_en;
    logic          psync;
    logic          ack0, ack1;
    logic [7:0]    dout0, dout1;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_din;
    logic          bus_wr, bus_rd;
    logic [7:0]    bus_dout;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_errors = 0;

    anton_neopixel_bus_arbiter #(.ADDR_BITS(AW)) dut (
        .busClk(clk), .busReset(rst),
        .m0Req(req[0]), .m0Write(wr[0]), .m0Addr(addr[0]), .m0DataIn(wdat[0]),
        .m0Ack(ack0), .m0DataOut(dout0),
        .m1Req(req[1]), .m1Write(wr[1]), .m1Addr(addr[1]), .m1DataIn(wdat[1]),
        .m1Ack(ack1), .m1DataOut(dout1),
        .syncLockEn(lock_en), .pixelsSync(psync),
        .busAddr(bus_addr), .busDataIn(bus_din), .busWrite(bus_wr), .busRead(bus_rd),
        .busDataOut(bus_dout), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Controller read data is a fixed function of the address; junk otherwise
    function automatic logic [7:0] ctl_val(input logic [AW-1:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3E;
    endfunction

    always @(posedge clk) bus_dout <= bus_rd ? ctl_val(bus_addr) : 8'($urandom);

    // Reference model: one transaction at a time, scheduled by cycle offsets
    int            cyc = 0;
    int            next_decide = 0;
    int            start = 0;
    bit            live = 1'b0;
    bit            have = 1'b0;
    bit            t_owner, t_w, mptr;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;
    logic [7:0]    e_dout [2];

    function automatic bit eligible(input int m);
        return req[m] && !(wr[m] && !addr[m][AW-1] && lock_en && !psync);
    endfunction

    always @(posedge clk) begin : ref_model
        bit e0, e1, own;
        cyc++;
        if (rst) begin
            live = 1'b1; have = 1'b0; mptr = 1'b0; next_decide = cyc + 1;
            e_dout[0] = 8'h00; e_dout[1] = 8'h00; e_addr = '0; e_data = 8'h00;
        end else if (live) begin
            if (have && !t_w && (cyc - start) == 2) e_dout[t_owner] = ctl_val(e_addr);
            if (cyc >= next_decide) begin
                e0 = eligible(0);
                e1 = eligible(1);
                if (e0 || e1) begin
                    own = (e0 && e1) ? mptr : e1;
                    have = 1'b1; t_owner = own; t_w = wr[own]; start = cyc;
                    e_addr = addr[own]; e_data = wdat[own];
                    next_decide = cyc + (t_w ? 3 : 4);
                    mptr = ~own;
                end
            end
        end
    end

    int bw_cnt = 0;
    int br_cnt = 0;

    always @(negedge clk) begin : scoreboard
        int d;
        logic [1:0] g;
        logic ew, er, ea;
        if (live) begin
            d  = have ? cyc - start : 99;
            g  = 2'b00;
            if (have && (d <= 1 || (d == 2 && !t_w))) g = t_owner ? 2'b10 : 2'b01;
            ew = have && d == 0 && t_w;
            er = have && d == 0 && !t_w;
            ea = have && ((t_w && d == 1) || (!t_w && d == 2));
            check_val("grant", 32'(grant), 32'(g));
            check_val("busWrite", 32'(bus_wr), 32'(ew));
            check_val("busRead", 32'(bus_rd), 32'(er));
            check_val("busAddr", 32'(bus_addr), 32'(e_addr));
            check_val("busDataIn", 32'(bus_din), 32'(e_data));
            check_val("m0Ack", 32'(ack0), 32'(ea && !t_owner));
            check_val("m1Ack", 32'(ack1), 32'(ea && t_owner));
            check_val("m0DataOut", 32'(dout0), 32'(e_dout[0]));
            check_val("m1DataOut", 32'(dout1), 32'(e_dout[1]));
            check_val("both_acks", 32'(ack0 & ack1), 32'd0);
            bw_cnt += int'(bus_wr);
            br_cnt += int'(bus_rd);
        end
    end

    // Master drivers
    bit [1:0] auto_req = 2'b00;
    bit       rnd_mode = 1'b0;
    int       cool [2] = '{0, 0};

    function automatic logic ackv(input int m);
        return (m == 1) ? ack1 : ack0;
    endfunction

    task automatic rand_fields(input int m);
        wr[m]   = 1'($urandom_range(0, 1));
        addr[m] = AW'($urandom);
        wdat[m] = 8'($urandom);
    endtask

    task automatic req_set(input int m, input logic w, input logic [AW-1:0] a, input logic [7:0] d);
        wr[m] = w; addr[m] = a; wdat[m] = d; req[m] = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (ackv(m)) begin
                req[m]  = 1'b0;
                cool[m] = rnd_mode ? int'($urandom_range(0, 3)) : 0;
            end else if (auto_req[m] && !req[m]) begin
                if (cool[m] > 0) cool[m]--;
                else begin
                    if (rnd_mode) rand_fields(m);
                    req[m] = 1'b1;
                end
            end else if (rnd_mode && req[m] && $urandom_range(0, 7) == 0) begin
                rand_fields(m);
            end
        end
    endtask

    task automatic wait_ack(input int m, input int maxc, output int lat);
        lat = 0;
        while (!ackv(m) && lat < maxc) begin
            tick();
            lat++;
        end
        if (!ackv(m)) check_val("ack_timeout", 32'(ackv(m)), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic first_ack(input string tag, input logic [1:0] exp);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(ack0 || ack1) && n < 12);
        check_val(tag, 32'({ack1, ack0}), 32'(exp));
    endtask

    initial begin
        int lat, b, n;
        rst = 1'b1; req = 2'b00; wr = 2'b00; lock_en = 1'b0; psync = 1'b0;
        addr[0] = '0; addr[1] = '0; wdat[0] = 8'h00; wdat[1] = 8'h00;
        do_reset();
        tick();

        // Single write from master 0
        b = bw_cnt;
        req_set(0, 1'b1, 14'h0005, 8'hA5);
        wait_ack(0, 8, lat);
        check_val("wr_latency", 32'(lat), 32'd2);
        check_val("wr_strobes", 32'(bw_cnt - b), 32'd1);
        tick();

        // Single read from master 1
        b = br_cnt;
        req_set(1, 1'b0, 14'h2002, 8'h00);
        wait_ack(1, 8, lat);
        check_val("rd_latency", 32'(lat), 32'd3);
        check_val("rd_data", 32'(dout1), 32'h1C);
        check_val("rd_strobes", 32'(br_cnt - b), 32'd1);
        tick();

        // Round-robin with both masters requesting continuously
        do_reset();
        auto_req = 2'b11;
        req_set(0, 1'b1, 14'h0011, 8'h01);
        req_set(1, 1'b1, 14'h0022, 8'h02);
        for (int k = 0; k < 4; k++) first_ack("rr_order", (k % 2 == 1) ? 2'b10 : 2'b01);
        auto_req = 2'b00;
        repeat (12) tick();

        // Frame lock: buffer write waits, register read passes
        lock_en = 1'b1; psync = 1'b0;
        req_set(0, 1'b1, 14'h0003, 8'h77);
        req_set(1, 1'b0, 14'h2003, 8'h00);
        wait_ack(1, 8, lat);
        check_val("lock_m1_latency", 32'(lat), 32'd3);
        b = bw_cnt;
        n = 0;
        repeat (6) begin
            tick();
            n += int'(ack0);
        end
        check_val("lock_held", 32'(n + bw_cnt - b), 32'd0);
        psync = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus_wr && n < 4);
        check_val("lock_release", 32'(n), 32'd1);
        wait_ack(0, 4, lat);
        tick();
        psync = 1'b0;
        req_set(0, 1'b1, 14'h2003, 8'h3C);
        wait_ack(0, 8, lat);
        check_val("lock_reg_wr", 32'(lat), 32'd2);
        lock_en = 1'b0;
        tick();

        // Reset during WAIT of a read; pointer had moved to master 1
        req_set(0, 1'b1, 14'h0010, 8'h11);
        wait_ack(0, 8, lat);
        tick();
        req_set(0, 1'b0, 14'h0010, 8'h00);
        tick();
        check_val("rd_issue", 32'(bus_rd), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_val("rst_no_ack", 32'(ack0), 32'd0);
        check_val("rst_grant", 32'(grant), 32'd0);
        req_set(1, 1'b1, 14'h0020, 8'h22);
        rst = 1'b0;
        first_ack("rst_rr_first", 2'b01);
        repeat (12) tick();

        // Random traffic
        rnd_mode = 1'b1;
        auto_req = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lock_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) psync = ~psync;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        rnd_mode = 1'b0;
        auto_req = 2'b00;
        psync = 1'b1;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/anton_neopixel_bus_arbiter.md
# anton_neopixel_bus_arbiter

Two-master arbiter and sequencer for the NeoPixel controller's byte bus. It shares the single `busAddr`/`busDataIn`/`busWrite`/`busRead`/`busDataOut` port between two requesters (e.g. CPU bridge and animation engine) using round-robin priority. It performs the one-cycle read latency of the controller on their behalf. Optionally, it holds pixel-buffer writes until the strip is in its reset/latch window so frames never tear.

## Interface
- `ADDR_BITS`, 14: bus address width; bit `ADDR_BITS-1` = 0 selects pixel buffer, 1 selects registers.
- `busClk` in 1: the one clock; all logic on its rising edge.
- `busReset` in 1: reset, synchronous, active-high.
- `m0Req` in 1: master 0 transaction request; held until `m0Ack`.
- `m0Write` in 1: 1 = write, 0 = read.
- `m0Addr` in `ADDR_BITS`: master 0 address.
- `m0DataIn` in 8: master 0 write data.
- `m0Ack` out 1: one-cycle completion pulse.
- `m0DataOut` out 8: read data; valid while `m0Ack`=1, held until next master-0 read.
- `m1Req`, `m1Write`, `m1Addr`, `m1DataIn`, `m1Ack`, `m1DataOut`: identical set for master 1.
- `syncLockEn` in 1: 1 = buffer writes wait for `pixelsSync`=1.
- `pixelsSync` in 1: controller reset-window flag, already synchronised to `busClk`.
- `busAddr` out `ADDR_BITS`: to controller.
- `busDataIn` out 8: to controller.
- `busWrite` out 1: to controller.
- `busRead` out 1: to controller.
- `busDataOut` in 8: from controller; valid the cycle after `busRead`.
- `grant` out 2: one-hot owner of the current transaction, 00 when idle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: evaluate eligible requests. A request is eligible if `mXReq`=1 and it is not a locked buffer write. A locked buffer write is `mXWrite`=1, `mXAddr[ADDR_BITS-1]`=0, `syncLockEn`=1 and `pixelsSync`=0.
  - If any request is eligible, select one, latch its addr/data/write into internal registers, set `grant`, and go to ISSUE.
  - Reads and register accesses are never locked.
  - A locked master does not block the other (no head-of-line blocking).
- Arbitration: a single priority pointer (reset → master 0).
  - Only one eligible: that master wins.
  - Both eligible: the pointer's master wins.
  - The pointer moves to the other master when a transaction reaches ACK.
- ISSUE: drive latched `busAddr`/`busDataIn`. Assert `busWrite` or `busRead` for exactly this one cycle. Next state is ACK for a write, WAIT for a read.
- WAIT: `busWrite`=`busRead`=0. Capture `busDataOut` into the granted master's `mXDataOut`. Go to ACK.
- ACK: pulse the granted `mXAck` for one cycle, clear `grant`, update the pointer, return to IDLE.
- The master must drop `mXReq` in the cycle after `mXAck` or it is treated as a new request.
- Changes to `mXAddr`/`mXDataIn`/`mXWrite` after grant are ignored (latched values are used).
- Dropping `mXReq` before ack is a protocol violation. The transaction still completes and ack still pulses.
- `busAddr`/`busDataIn` hold their last values outside ISSUE. Strobes are 0 outside ISSUE.
- `busWrite` and `busRead` are never both 1.

## Timing
- Reset values: `grant`=00; `m0Ack`=`m1Ack`=0; `m0DataOut`=`m1DataOut`=8'h00; `busWrite`=`busRead`=0; `busAddr`=0; `busDataIn`=0; FSM=IDLE; pointer=master 0.
- `busReset` in any state aborts the transaction with no ack. A strobe already issued is not retracted; the controller sees at most one strobe.
- Cycle numbering: request sampled in IDLE at edge E0.
  - ISSUE is the cycle after E0.
  - Write: ack in cycle E0+2.
  - Read: ack in cycle E0+3.
- Back-to-back: IDLE occupies one cycle between transactions.
  - Write throughput: one write per 3 cycles.
  - Read throughput: one read per 4 cycles.
- Both masters requesting continuously alternate strictly.
- `pixelsSync` is sampled only in IDLE. A lock window closing during ISSUE/ACK does not cancel the granted write.

## Test plan
- **Single write:** reset; `m0Req`=1, write, addr 14'h0005, data 8'hA5. Required: `busWrite` high one cycle with addr 5, data A5; `m0Ack` at E0+2; `grant`=01 during ISSUE/ACK.
- **Single read:** `m1` reads 14'h2002; model returns 8'h1C the cycle after `busRead`. Required: `m1Ack` at E0+3 with `m1DataOut`=1C; `busRead` exactly one cycle.
- **Round-robin:** both masters hold write requests for 4 transactions after reset. Required: grant order m0, m1, m0, m1; no cycle with both acks high.
- **Frame lock:** `syncLockEn`=1, `pixelsSync`=0; m0 writes buffer addr 3 while m1 reads register 3. Required: m1 served, m0 waits. Raise `pixelsSync` → m0's write issues within 2 cycles. Repeat with a register write by m0: it is never blocked.
- **Reset mid-read:** assert `busReset` during WAIT. Required: no `m0Ack`; all outputs return to reset values next cycle; the next transaction after reset is granted to m0 when both request.
